// File: rtl/cpu_fpu_pkg.sv
// Shared FPU constants and types: field widths, bias, integer limits, flag positions
// and the conversion-stage state encoding.
package cpu_fpu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClassify,
      StShift,
      StPack,
      StDone
   } fpu_state_e;

   localparam int unsigned FP_EXP_W  = 8;
   localparam int unsigned FP_FRAC_W = 23;
   localparam int          FP_BIAS   = 127;

   localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

   // Bit positions inside the {NV,NX} flag vector.
   localparam int unsigned FLAG_NV = 1;
   localparam int unsigned FLAG_NX = 0;

endpackage

// File: rtl/cpu_fpu_float_to_int.sv
// FCVT.W.S / FCVT.WU.S: single-precision float to 32-bit integer, round toward zero,
// one right shift per cycle. Define CPU_FPU_FLAGS_EN to add the {NV,NX} o_flags port.
module cpu_fpu_float_to_int
   import cpu_fpu_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic [31:0] i_op1,
   input  logic        i_signed,
   output logic        o_ready,
   output logic [31:0] o_result
`ifdef CPU_FPU_FLAGS_EN
   ,
   output logic [1:0]  o_flags
`endif
);

   fpu_state_e        state_q;
   logic [31:0]       op_q;
   logic              signed_q;
   logic [31:0]       m_q;
   logic [4:0]        n_q;
   logic [31:0]       res_q;
   logic              special_q;
`ifdef CPU_FPU_FLAGS_EN
   logic              sticky_q;
   logic              nv_q;
   logic              nx_q;
`endif

   logic                 sign;
   logic [FP_EXP_W-1:0]  exp_b;
   logic [FP_FRAC_W-1:0] frac;
   logic signed [8:0]    exp_u;
   logic [31:0]          sat;
   logic [31:0]          cls_res;
   logic [4:0]           cls_n;
   logic                 cls_special;
   logic                 cls_nv;
   logic                 cls_nx;

   always_comb begin
      sign  = op_q[31];
      exp_b = op_q[FP_FRAC_W +: FP_EXP_W];
      frac  = op_q[FP_FRAC_W-1:0];
      exp_u = $signed({1'b0, exp_b}) - $signed(9'(FP_BIAS));
      sat   = sign ? (signed_q ? INT_MIN : 32'h0) : (signed_q ? INT_MAX : UINT_MAX);

      cls_res     = 32'h0;
      cls_n       = 5'd0;
      cls_special = 1'b1;
      cls_nv      = 1'b0;
      cls_nx      = 1'b0;
      if (exp_b == '1 && frac != '0) begin
         cls_res = signed_q ? INT_MAX : UINT_MAX;
         cls_nv  = 1'b1;
      end else if (exp_b == '0) begin
         // Denormals are flushed to zero but still report inexact.
         cls_nx = (frac != '0);
      end else if (exp_u < 9'sd0) begin
         cls_nx = 1'b1;
      end else if (!signed_q && sign) begin
         cls_nv = 1'b1;
      end else if (exp_u > 9'sd31 ||
                   (signed_q && exp_u == 9'sd31 && !(sign && frac == '0))) begin
         cls_res = sat;
         cls_nv  = 1'b1;
      end else begin
         cls_special = 1'b0;
         cls_n       = 5'd31 - exp_u[4:0];
      end
   end

`ifndef CPU_FPU_FLAGS_EN
   logic unused_flags;
   assign unused_flags = cls_nv ^ cls_nx;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= StIdle;
         o_ready   <= 1'b0;
         o_result  <= 32'h0;
         op_q      <= 32'h0;
         signed_q  <= 1'b0;
         m_q       <= 32'h0;
         n_q       <= 5'd0;
         res_q     <= 32'h0;
         special_q <= 1'b0;
`ifdef CPU_FPU_FLAGS_EN
         sticky_q  <= 1'b0;
         nv_q      <= 1'b0;
         nx_q      <= 1'b0;
         o_flags   <= 2'b00;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               o_ready <= 1'b0;
               if (i_request) begin
                  op_q     <= i_op1;
                  signed_q <= i_signed;
`ifdef CPU_FPU_FLAGS_EN
                  sticky_q <= 1'b0;
                  nv_q     <= 1'b0;
                  nx_q     <= 1'b0;
`endif
                  state_q  <= StClassify;
               end
            end
            StClassify: begin
               m_q       <= {1'b1, frac, 8'h00};
               n_q       <= cls_n;
               res_q     <= cls_res;
               special_q <= cls_special;
`ifdef CPU_FPU_FLAGS_EN
               nv_q      <= cls_nv;
               nx_q      <= cls_nx;
`endif
               state_q   <= (cls_n == 5'd0) ? StPack : StShift;
            end
            StShift: begin
               m_q <= m_q >> 1;
               n_q <= n_q - 5'd1;
`ifdef CPU_FPU_FLAGS_EN
               sticky_q <= sticky_q | m_q[0];
`endif
               if (n_q == 5'd1) begin
                  state_q <= StPack;
               end
            end
            StPack: begin
               if (!special_q) begin
                  res_q <= (signed_q && sign) ? (~m_q + 32'd1) : m_q;
`ifdef CPU_FPU_FLAGS_EN
                  nx_q  <= nx_q | sticky_q;
`endif
               end
               state_q <= StDone;
            end
            StDone: begin
               o_ready  <= 1'b1;
               o_result <= res_q;
`ifdef CPU_FPU_FLAGS_EN
               o_flags  <= {nv_q, nx_q};
`endif
               if (!i_request) begin
                  o_ready <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               o_ready <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fpu_float_to_int.sv
// Bench for cpu_fpu_float_to_int: directed vector table, handshake/reset sequences and
// randomized operands checked against an arithmetic reference model.
module tb_cpu_fpu_float_to_int;

   logic        clk;
   logic        rst;
   logic        req;
   logic [31:0] op1;
   logic        sgn;
   logic        ready;
   logic [31:0] result;
   logic [1:0]  flags_w;

   int checks   = 0;
   int failures = 0;

   cpu_fpu_float_to_int dut (
      .i_clock  (clk),
      .i_reset  (rst),
      .i_request(req),
      .i_op1    (op1),
      .i_signed (sgn),
      .o_ready  (ready),
      .o_result (result)
`ifdef CPU_FPU_FLAGS_EN
      ,
      .o_flags  (flags_w)
`endif
   );

`ifndef CPU_FPU_FLAGS_EN
   assign flags_w = 2'b00;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] op;
      bit          sgn;
      logic [31:0] res;
      logic [1:0]  flg;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Raise a request, then count edges after the accept edge until o_ready is seen.
   task automatic run_req(input logic [31:0] op, input bit s, output logic [31:0] res,
                          output logic [1:0] flg, output int lat);
      @(negedge clk);
      req = 1'b1;
      op1 = op;
      sgn = s;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ready && lat < 60);
      res = result;
      flg = flags_w;
   endtask

   task automatic drop_req();
      @(negedge clk);
      req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Reference: exact truncated magnitude, then range rules applied to the integer value.
   task automatic model(input logic [31:0] op, input bit s_int, output logic [31:0] res,
                        output logic [1:0] flg, output int lat);
      bit     neg;
      int     ex;
      int     fr;
      int     e;
      longint mant;
      longint mag;
      bit     inexact;
      bit     huge;
      neg     = op[31];
      ex      = int'(op[30:23]);
      fr      = int'(op[22:0]);
      e       = ex - 127;
      lat     = 3;
      flg     = 2'b00;
      res     = 32'h0;
      mag     = 0;
      inexact = 1'b0;
      huge    = 1'b0;
      if (ex == 255 && fr != 0) begin
         res = s_int ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
         flg = 2'b10;
         return;
      end
      if (ex == 0) begin
         flg = {1'b0, fr != 0};
         return;
      end
      mant = longint'(fr) + (64'sd1 <<< 23);
      if (e > 40) huge = 1'b1;
      else if (e < 0) begin
         mag = 0;
         inexact = 1'b1;
      end else if (e >= 23) mag = mant <<< (e - 23);
      else begin
         mag = mant >>> (23 - e);
         inexact = ((mag <<< (23 - e)) != mant);
      end
      if (s_int) begin
         if (huge || (neg ? mag > 64'sd2147483648 : mag > 64'sd2147483647)) begin
            res = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            flg = 2'b10;
            return;
         end
         res = neg ? 32'(-mag) : 32'(mag);
      end else begin
         if (huge || (!neg && mag > 64'sd4294967295)) begin
            res = neg ? 32'h0 : 32'hFFFF_FFFF;
            flg = 2'b10;
            return;
         end
         if (neg && mag != 0) begin
            flg = 2'b10;
            return;
         end
         res = 32'(mag);
      end
      flg = {1'b0, inexact};
      lat = (e < 0) ? 3 : 34 - e;
   endtask

   vec_t        vecs[14];
   logic [31:0] got;
   logic [1:0]  gflg;
   int          glat;
   logic [31:0] mres;
   logic [1:0]  mflg;
   int          mlat;
   logic [31:0] rop;

   initial begin
      vecs[0]  = '{32'h40490FDB, 1'b1, 32'h0000_0003, 2'b01, 33};
      vecs[1]  = '{32'hC2F60000, 1'b1, 32'hFFFF_FF85, 2'b00, 28};
      vecs[2]  = '{32'hC2F60000, 1'b0, 32'h0000_0000, 2'b10, 3};
      vecs[3]  = '{32'h4F000000, 1'b1, 32'h7FFF_FFFF, 2'b10, 3};
      vecs[4]  = '{32'h4F000000, 1'b0, 32'h8000_0000, 2'b00, 3};
      vecs[5]  = '{32'hCF000000, 1'b1, 32'h8000_0000, 2'b00, 3};
      vecs[6]  = '{32'h7FC00000, 1'b1, 32'h7FFF_FFFF, 2'b10, 3};
      vecs[7]  = '{32'h7FC00000, 1'b0, 32'hFFFF_FFFF, 2'b10, 3};
      vecs[8]  = '{32'hFF800000, 1'b1, 32'h8000_0000, 2'b10, 3};
      vecs[9]  = '{32'hBF000000, 1'b0, 32'h0000_0000, 2'b01, 3};
      vecs[10] = '{32'h00000001, 1'b1, 32'h0000_0000, 2'b01, 3};
      vecs[11] = '{32'h3F800000, 1'b1, 32'h0000_0001, 2'b00, 34};
      vecs[12] = '{32'h4B7FFFFF, 1'b0, 32'h00FF_FFFF, 2'b00, 11};
      vecs[13] = '{32'h3FC00000, 1'b1, 32'h0000_0001, 2'b01, 34};

      rst = 1'b1;
      req = 1'b0;
      op1 = 32'h0;
      sgn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'h0, ready}, 32'h0);
      check("reset_result", result, 32'h0);
`ifdef CPU_FPU_FLAGS_EN
      check("reset_flags", {30'h0, flags_w}, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_req(vecs[i].op, vecs[i].sgn, got, gflg, glat);
         check($sformatf("vec%0d_result", i), got, vecs[i].res);
         check($sformatf("vec%0d_latency", i), 32'(glat), 32'(vecs[i].lat));
`ifdef CPU_FPU_FLAGS_EN
         check($sformatf("vec%0d_flags", i), {30'h0, gflg}, {30'h0, vecs[i].flg});
`endif
         drop_req();
      end

      // Handshake: result held while request stays high, ready falls on the drop edge.
      run_req(32'hC2F60000, 1'b1, got, gflg, glat);
      check("hs_first", got, 32'hFFFF_FF85);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hs_hold_ready%0d", k), {31'h0, ready}, 32'h1);
         check($sformatf("hs_hold_result%0d", k), result, 32'hFFFF_FF85);
      end
      drop_req();
      check("hs_drop_ready", {31'h0, ready}, 32'h0);
      check("hs_drop_result_kept", result, 32'hFFFF_FF85);
      run_req(32'h3F800000, 1'b1, got, gflg, glat);
      check("hs_rerequest", got, 32'h1);
      drop_req();

      // Reset in the middle of the shift sequence.
      @(negedge clk);
      req = 1'b1;
      op1 = 32'h3F800000;
      sgn = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      req = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_ready", {31'h0, ready}, 32'h0);
      check("rst_mid_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run_req(32'h4B7FFFFF, 1'b1, got, gflg, glat);
      check("rst_after_result", got, 32'h00FF_FFFF);
      check("rst_after_latency", 32'(glat), 32'd11);
      drop_req();

      for (int r = 0; r < 40; r++) begin
         rop = $urandom;
         if (r % 4 != 0) rop[30:23] = 8'($urandom_range(110, 162));
         run_req(rop, 1'($urandom_range(0, 1)), got, gflg, glat);
         model(rop, sgn, mres, mflg, mlat);
         check($sformatf("rnd%0d_result_op%h_s%0d", r, rop, sgn), got, mres);
         check($sformatf("rnd%0d_latency", r), 32'(glat), 32'(mlat));
`ifdef CPU_FPU_FLAGS_EN
         check($sformatf("rnd%0d_flags", r), {30'h0, gflg}, {30'h0, mflg});
`endif
         drop_req();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
